// File: rtl/riscv_pkg.sv
// Shared RV32I execute-stage constants: datapath width, ALU opcodes and
// hazard-unit forwarding selects.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU: ADD/SUB/AND/OR/signed SLT, unused opcodes give 0.
module alu
  import riscv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [2:0]   ALUControl,
  output logic [W-1:0] Result,
  output logic         Zero,
  output logic         Negative
);

  logic w_slt;

  // Signed compare rather than sign-of-difference, so overflow cannot flip it.
  assign w_slt = ($signed(A) < $signed(B));

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = A + B;
      ALU_SUB: Result = A - B;
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_SLT: Result = {{(W-1){1'b0}}, w_slt};
      default: Result = '0;
    endcase
  end

  assign Zero     = (Result == '0);
  assign Negative = Result[W-1];

endmodule

// File: rtl/execute_cycle.sv
// RV32I Execute stage: operand forwarding, ALU, beq resolution, branch
// target adder and the EX/MEM pipeline register feeding memory_cycle.
module execute_cycle
  import riscv_pkg::*;
#(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteE,
  input  logic                  MemWriteE,
  input  logic                  ResultSrcE,
  input  logic                  BranchE,
  input  logic                  ALUSrcE,
  input  logic [2:0]            ALUControlE,
  input  logic [XLEN-1:0]       RD1_E,
  input  logic [XLEN-1:0]       RD2_E,
  input  logic [XLEN-1:0]       Imm_Ext_E,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic [XLEN-1:0]       PCE,
  input  logic [XLEN-1:0]       PCPlus4E,
  input  logic [XLEN-1:0]       ResultW,
  input  logic [1:0]            ForwardA_E,
  input  logic [1:0]            ForwardB_E,
  output logic                  PCSrcE,
  output logic [XLEN-1:0]       PCTargetE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic                  ResultSrcM,
  output logic [REG_ADDR_W-1:0] RD_M,
  output logic [XLEN-1:0]       PCPlus4M,
  output logic [XLEN-1:0]       WriteDataM,
  output logic [XLEN-1:0]       ALU_ResultM
);

  logic [XLEN-1:0]       w_src_a;
  logic [XLEN-1:0]       w_fwd_b;
  logic [XLEN-1:0]       w_src_b;
  logic [XLEN-1:0]       w_alu_result;
  logic                  w_zero;

  logic                  r_reg_write;
  logic                  r_mem_write;
  logic                  r_result_src;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_pc_plus4;
  logic [XLEN-1:0]       r_write_data;
  logic [XLEN-1:0]       r_alu_result;

  // The MEM forward source is the pre-edge EX/MEM value, so dependent
  // back-to-back ALU ops see the previous instruction's result.
  always_comb begin
    w_src_a = RD1_E;
    case (ForwardA_E)
      FWD_WB:  w_src_a = ResultW;
      FWD_MEM: w_src_a = r_alu_result;
      default: w_src_a = RD1_E;
    endcase
  end

  always_comb begin
    w_fwd_b = RD2_E;
    case (ForwardB_E)
      FWD_WB:  w_fwd_b = ResultW;
      FWD_MEM: w_fwd_b = r_alu_result;
      default: w_fwd_b = RD2_E;
    endcase
  end

  assign w_src_b = ALUSrcE ? Imm_Ext_E : w_fwd_b;

  alu #(
    .W (XLEN)
  ) u_alu (
    .A          (w_src_a),
    .B          (w_src_b),
    .ALUControl (ALUControlE),
    .Result     (w_alu_result),
    .Zero       (w_zero),
    .Negative   ()
  );

  assign PCSrcE    = BranchE & w_zero;
  assign PCTargetE = PCE + Imm_Ext_E;

  // No stall/enable: the register captures every edge; squashing is upstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 1'b0;
      r_rd         <= '0;
      r_pc_plus4   <= '0;
      r_write_data <= '0;
      r_alu_result <= '0;
    end else begin
      r_reg_write  <= RegWriteE;
      r_mem_write  <= MemWriteE;
      r_result_src <= ResultSrcE;
      r_rd         <= RD_E;
      r_pc_plus4   <= PCPlus4E;
      r_write_data <= w_fwd_b;
      r_alu_result <= w_alu_result;
    end
  end

  assign RegWriteM   = r_reg_write;
  assign MemWriteM   = r_mem_write;
  assign ResultSrcM  = r_result_src;
  assign RD_M        = r_rd;
  assign PCPlus4M    = r_pc_plus4;
  assign WriteDataM  = r_write_data;
  assign ALU_ResultM = r_alu_result;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed self-checking bench for execute_cycle: reset, ALU ops, forwarding,
// beq resolution and asynchronous mid-stream reset.
module tb_execute_cycle;

  logic        clk;
  logic        rst;
  logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

  int n_checks = 0;
  int n_fail   = 0;

  execute_cycle dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteE   (RegWriteE),
    .MemWriteE   (MemWriteE),
    .ResultSrcE  (ResultSrcE),
    .BranchE     (BranchE),
    .ALUSrcE     (ALUSrcE),
    .ALUControlE (ALUControlE),
    .RD1_E       (RD1_E),
    .RD2_E       (RD2_E),
    .Imm_Ext_E   (Imm_Ext_E),
    .RD_E        (RD_E),
    .PCE         (PCE),
    .PCPlus4E    (PCPlus4E),
    .ResultW     (ResultW),
    .ForwardA_E  (ForwardA_E),
    .ForwardB_E  (ForwardB_E),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .RD_M        (RD_M),
    .PCPlus4M    (PCPlus4M),
    .WriteDataM  (WriteDataM),
    .ALU_ResultM (ALU_ResultM)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_idle();
    RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0; ALUSrcE = 0;
    ALUControlE = 3'b000; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0;
    PCE = 0; PCPlus4E = 0; ResultW = 0; ForwardA_E = 2'b00; ForwardB_E = 2'b00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_idle();
    RD1_E = 32'd5; Imm_Ext_E = 32'd7; ALUSrcE = 1; RD_E = 5'd3; RegWriteE = 1;
    MemWriteE = 1; ResultSrcE = 1; PCPlus4E = 32'h104; RD2_E = 32'h55;
    #100;
    $display("reset held: alu=%h rd=%0d wd=%h", ALU_ResultM, RD_M, WriteDataM);
    n_checks++;
    if (ALU_ResultM !== 32'h0) begin n_fail++; $display("FAIL reset_alu got %h want 0", ALU_ResultM); end
    n_checks++;
    if ({RegWriteM, MemWriteM, ResultSrcM} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 000", {RegWriteM, MemWriteM, ResultSrcM});
    end
    n_checks++;
    if (RD_M !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %0d want 0", RD_M); end
    n_checks++;
    if ({PCPlus4M, WriteDataM} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data got %h/%h want 0/0", PCPlus4M, WriteDataM);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    $display("first capture: alu=%h rd=%0d wd=%h pc4=%h", ALU_ResultM, RD_M, WriteDataM, PCPlus4M);
    n_checks++;
    if (ALU_ResultM !== 32'hC) begin n_fail++; $display("FAIL first_alu got %h want 0000000c", ALU_ResultM); end
    n_checks++;
    if ({RegWriteM, MemWriteM, ResultSrcM} !== 3'b111) begin
      n_fail++; $display("FAIL first_ctrl got %b want 111", {RegWriteM, MemWriteM, ResultSrcM});
    end
    n_checks++;
    if (RD_M !== 5'd3 || WriteDataM !== 32'h55 || PCPlus4M !== 32'h104) begin
      n_fail++; $display("FAIL first_regs got rd=%0d wd=%h pc4=%h want 3/55/104", RD_M, WriteDataM, PCPlus4M);
    end
  endtask

  task automatic test_add();
    @(negedge clk);
    set_idle();
    RD1_E = 32'd5; Imm_Ext_E = 32'd7; ALUSrcE = 1; RD_E = 5'd2; RegWriteE = 1;
    tick();
    $display("add 5+7: alu=%h rd=%0d rw=%b", ALU_ResultM, RD_M, RegWriteM);
    n_checks++;
    if (ALU_ResultM !== 32'hC || RD_M !== 5'd2 || RegWriteM !== 1'b1 || MemWriteM !== 1'b0) begin
      n_fail++; $display("FAIL add got alu=%h rd=%0d rw=%b mw=%b want c/2/1/0", ALU_ResultM, RD_M, RegWriteM, MemWriteM);
    end
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    set_idle();
    RD1_E = 32'hC; Imm_Ext_E = 32'd4; ALUSrcE = 1;
    tick();
    $display("fwd setup: alu=%h", ALU_ResultM);
    n_checks++;
    if (ALU_ResultM !== 32'h10) begin n_fail++; $display("FAIL fwd_setup got %h want 10", ALU_ResultM); end
    @(negedge clk);
    ForwardA_E = 2'b10; RD1_E = 32'hDEAD; Imm_Ext_E = 32'd4;
    ForwardB_E = 2'b01; ResultW = 32'hAABBCCDD; RD2_E = 32'h1111;
    tick();
    $display("fwd mem/wb: alu=%h wd=%h", ALU_ResultM, WriteDataM);
    n_checks++;
    if (ALU_ResultM !== 32'h14) begin n_fail++; $display("FAIL fwd_a_mem got %h want 14", ALU_ResultM); end
    n_checks++;
    if (WriteDataM !== 32'hAABBCCDD) begin n_fail++; $display("FAIL fwd_b_wb got %h want aabbccdd", WriteDataM); end
    // back-to-back dependent op: uses 0x14 from EX/MEM
    tick();
    $display("back-to-back: alu=%h", ALU_ResultM);
    n_checks++;
    if (ALU_ResultM !== 32'h18) begin n_fail++; $display("FAIL back_to_back got %h want 18", ALU_ResultM); end
    @(negedge clk);
    ForwardA_E = 2'b11; ForwardB_E = 2'b11; RD1_E = 32'h100; RD2_E = 32'h2222;
    ALUSrcE = 0; ALUControlE = 3'b011;
    tick();
    $display("fwd 11: alu=%h wd=%h", ALU_ResultM, WriteDataM);
    n_checks++;
    if (ALU_ResultM !== 32'h2322 || WriteDataM !== 32'h2222) begin
      n_fail++; $display("FAIL fwd_11 got alu=%h wd=%h want 2322/2222", ALU_ResultM, WriteDataM);
    end
  endtask

  task automatic test_beq();
    @(negedge clk);
    set_idle();
    BranchE = 1; ALUControlE = 3'b001; RD1_E = 32'd9; RD2_E = 32'd9; PCE = 32'h100; Imm_Ext_E = 32'h20;
    #1;
    $display("beq 9,9: pcsrc=%b target=%h", PCSrcE, PCTargetE);
    n_checks++;
    if (PCSrcE !== 1'b1) begin n_fail++; $display("FAIL beq_taken got %b want 1", PCSrcE); end
    n_checks++;
    if (PCTargetE !== 32'h120) begin n_fail++; $display("FAIL beq_target got %h want 120", PCTargetE); end
    RD2_E = 32'd8;
    #1;
    $display("beq 9,8: pcsrc=%b", PCSrcE);
    n_checks++;
    if (PCSrcE !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken got %b want 0", PCSrcE); end
    RD2_E = 32'd9; BranchE = 0;
    #1;
    n_checks++;
    if (PCSrcE !== 1'b0) begin n_fail++; $display("FAIL nobranch_equal got %b want 0", PCSrcE); end
    PCE = 32'hFFFFFFF0; Imm_Ext_E = 32'h20;
    #1;
    $display("target wrap: target=%h", PCTargetE);
    n_checks++;
    if (PCTargetE !== 32'h10) begin n_fail++; $display("FAIL target_wrap got %h want 10", PCTargetE); end
  endtask

  task automatic test_alu_ops();
    @(negedge clk);
    set_idle();
    ALUControlE = 3'b101; RD1_E = 32'h80000000; RD2_E = 32'h7FFFFFFF;
    tick();
    $display("slt min<max: alu=%h", ALU_ResultM);
    n_checks++;
    if (ALU_ResultM !== 32'h1) begin n_fail++; $display("FAIL slt_overflow got %h want 1", ALU_ResultM); end
    @(negedge clk);
    RD1_E = 32'h7FFFFFFF; RD2_E = 32'h80000000;
    tick();
    n_checks++;
    if (ALU_ResultM !== 32'h0) begin n_fail++; $display("FAIL slt_reverse got %h want 0", ALU_ResultM); end
    @(negedge clk);
    ALUControlE = 3'b000; RD1_E = 32'hFFFFFFFF; Imm_Ext_E = 32'd1; ALUSrcE = 1; BranchE = 1;
    #1;
    n_checks++;
    if (PCSrcE !== 1'b1) begin n_fail++; $display("FAIL add_wrap_zero got %b want 1", PCSrcE); end
    tick();
    $display("add ffffffff+1: alu=%h", ALU_ResultM);
    n_checks++;
    if (ALU_ResultM !== 32'h0) begin n_fail++; $display("FAIL add_wrap got %h want 0", ALU_ResultM); end
    @(negedge clk);
    BranchE = 0; ALUSrcE = 0; ALUControlE = 3'b010; RD1_E = 32'hF0F0FF00; RD2_E = 32'h0FF0F0F0;
    tick();
    n_checks++;
    if (ALU_ResultM !== 32'h00F0F000) begin n_fail++; $display("FAIL and got %h want 00f0f000", ALU_ResultM); end
    @(negedge clk);
    ALUControlE = 3'b111;
    tick();
    $display("op 111: alu=%h", ALU_ResultM);
    n_checks++;
    if (ALU_ResultM !== 32'h0) begin n_fail++; $display("FAIL op111 got %h want 0", ALU_ResultM); end
    @(negedge clk);
    ALUControlE = 3'b000;
    tick();
    @(negedge clk);
    ALUControlE = 3'b100;
    tick();
    n_checks++;
    if (ALU_ResultM !== 32'h0) begin n_fail++; $display("FAIL op100 got %h want 0", ALU_ResultM); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    set_idle();
    RD1_E = 32'hABCDEF00; ALUSrcE = 1; RD_E = 5'd7; RegWriteE = 1;
    tick();
    n_checks++;
    if (ALU_ResultM !== 32'hABCDEF00) begin n_fail++; $display("FAIL async_setup got %h want abcdef00", ALU_ResultM); end
    #2;
    rst = 1'b0;
    BranchE = 1; ALUSrcE = 0; ALUControlE = 3'b001; RD1_E = 32'd9; RD2_E = 32'd9;
    #1;
    $display("async reset mid-cycle: alu=%h rd=%0d pcsrc=%b", ALU_ResultM, RD_M, PCSrcE);
    n_checks++;
    if (ALU_ResultM !== 32'h0 || RD_M !== 5'd0 || RegWriteM !== 1'b0) begin
      n_fail++; $display("FAIL async_clear got alu=%h rd=%0d rw=%b want 0/0/0", ALU_ResultM, RD_M, RegWriteM);
    end
    n_checks++;
    if (PCSrcE !== 1'b1) begin n_fail++; $display("FAIL pcsrc_in_reset got %b want 1", PCSrcE); end
    tick();
    n_checks++;
    if (ALU_ResultM !== 32'h0) begin n_fail++; $display("FAIL reset_hold got %h want 0", ALU_ResultM); end
    @(negedge clk);
    rst = 1'b1;
    ALUControlE = 3'b000;
    tick();
    n_checks++;
    if (ALU_ResultM !== 32'd18) begin n_fail++; $display("FAIL post_reset got %h want 12", ALU_ResultM); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forwarding();
    test_beq();
    test_alu_ops();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
